// File: rtl/sonic_pkg.sv
// sonic_pkg: shared FSM state type and constants for the ultrasonic ranger
package sonic_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, CALC, HOLDOFF} state_t;
  localparam int unsigned US_PER_CM_X10 = 58;
  localparam int unsigned TICK_HZ = 1_000_000;
endpackage

// File: rtl/sonic_div.sv
// sonic_div: restoring unsigned divider, one quotient bit per cycle, done pulse W+1 cycles after start
// Ports: clk, rst (async active-low), start, dividend (W+4 bits), divisor, quotient, done.
// The top 4 dividend bits preload the remainder, so they must be below divisor; the quotient then fits W bits.
module sonic_div
  import sonic_pkg::*;
#(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W+3:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] rem;
  logic [CW-1:0] cnt;
  logic [W:0] trial;
  logic fits;
  always_comb begin
    trial = {rem, quotient[W-1]};
    fits = trial >= {1'b0, divisor};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rem <= '0;
      quotient <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (start) begin
      rem <= W'(dividend[W+3:W]);
      quotient <= dividend[W-1:0];
      cnt <= CW'(W);
      done <= 1'b0;
    end else begin
      done <= cnt == CW'(1);
      if (cnt != '0) begin
        rem <= fits ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
        quotient <= {quotient[W-2:0], fits};
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: rtl/sonic_ranging_ctrl.sv
// sonic_ranging_ctrl: HC-SR04 sequencer - trigger, echo timing on a 1 us tick, mm conversion, proximity flag
// Ports: clk, rst (async active-low); en continuous mode; req one-shot (IDLE only); echo raw sensor pin;
//        trig sensor trigger; busy not IDLE; dist_mm/dist_valid result; timeout lost/overlong echo; stop proximity.
// Build option SONIC_AVG_EN: stop compares a 4-sample moving average of valid distances instead of the raw value.
module sonic_ranging_ctrl
  import sonic_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 100,
  parameter int TIMEOUT_US = 30000,
  parameter int STOP_MM    = 400,
  parameter int HYST_MM    = 50,
  parameter int DIST_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req,
  input  logic              echo,
  output logic              trig,
  output logic              busy,
  output logic [DIST_W-1:0] dist_mm,
  output logic              dist_valid,
  output logic              timeout,
  output logic              stop
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int PER_US = PERIOD_MS * 1000;
  localparam int RW = $clog2(PER_US + 1);
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [RW-1:0] per;
  logic [DIST_W-1:0] cnt, cnt_n, cnt_inc, quotient, cmp;
  logic [DIST_W+3:0] ext, prod;
  logic tick, period_up, go, lost, div_start, div_done, s1, s2, s3, rise, fall, stop_n;
  always_comb begin
    tick = pre == PW'(TICK_DIV - 1);
    cnt_inc = tick && cnt != '1 ? cnt + 1'b1 : cnt;
    period_up = per == '0 || (per == RW'(1) && tick);
    rise = s2 && !s3;
    fall = s3 && !s2;
    ext = {4'b0, cnt};
    prod = (ext << 3) + (ext << 1);
    busy = state != IDLE;
    trig = state == TRIG;
  end
  // One counter serves as trigger timer, rise-wait timer and echo width (echo_us) in turn.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    go = 1'b0;
    lost = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        go = req || (en && period_up);
        state_n = go ? TRIG : IDLE;
      end
      TRIG: begin
        cnt_n = cnt_inc;
        if (tick && cnt == DIST_W'(TRIG_US - 1)) begin
          state_n = WAIT_RISE;
          cnt_n = '0;
        end
      end
      WAIT_RISE: begin
        cnt_n = cnt_inc;
        if (rise) begin
          state_n = MEASURE;
          cnt_n = DIST_W'(tick);
        end else if (tick && cnt == DIST_W'(TIMEOUT_US - 1)) lost = 1'b1;
      end
      MEASURE: begin
        cnt_n = s2 ? cnt_inc : cnt;
        if (fall) begin
          state_n = CALC;
          div_start = 1'b1;
        end else if (cnt >= DIST_W'(TIMEOUT_US)) lost = 1'b1;
      end
      CALC: state_n = div_done ? HOLDOFF : CALC;
      HOLDOFF: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (lost) state_n = HOLDOFF;
  end
  // Prescaler and period restart on trigger rise so trigger width and period are exact in clk cycles.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pre <= '0;
      per <= '0;
      cnt <= '0;
      {s3, s2, s1} <= 3'b0;
      dist_mm <= '0;
      dist_valid <= 1'b0;
      timeout <= 1'b0;
      stop <= 1'b0;
    end else begin
      state <= state_n;
      pre <= go || tick ? '0 : pre + 1'b1;
      per <= go ? RW'(PER_US) : tick && per != '0 ? per - 1'b1 : per;
      cnt <= cnt_n;
      {s3, s2, s1} <= {s2, s1, echo};
      dist_valid <= state == CALC && div_done;
      timeout <= lost;
      dist_mm <= lost ? '1 : state == CALC && div_done ? quotient : dist_mm;
      stop <= state == HOLDOFF ? stop_n : stop;
    end
  sonic_div #(.W(DIST_W)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend(prod),
    .divisor(DIST_W'(US_PER_CM_X10)),
    .quotient(quotient),
    .done(div_done)
  );
`ifdef SONIC_AVG_EN
  logic [DIST_W-1:0] h0, h1, h2;
  logic filled;
  logic [DIST_W+1:0] sum;
  // In HOLDOFF dist_mm already holds the newest sample; h0..h2 are the three before it.
  always_comb begin
    sum = filled ? {2'b0, dist_mm} + {2'b0, h0} + {2'b0, h1} + {2'b0, h2} : {dist_mm, 2'b00};
    cmp = sum[DIST_W+1:2];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {h0, h1, h2} <= '0;
      filled <= 1'b0;
    end else if (dist_valid) begin
      h0 <= dist_mm;
      h1 <= filled ? h0 : dist_mm;
      h2 <= filled ? h1 : dist_mm;
      filled <= 1'b1;
    end
`else
  always_comb cmp = dist_mm;
`endif
  always_comb stop_n = timeout ? 1'b0 : cmp < DIST_W'(STOP_MM) ? 1'b1 : cmp >= DIST_W'(STOP_MM + HYST_MM) ? 1'b0 : stop;
endmodule
